// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg -- shared definitions for the seven-segment sequence checker.
//
// Contents:
//   SEG_W, DIGIT_W, CNT_W  widths of a segment pattern, a decoded digit and
//                          the stability counter
//   SEG_0 .. SEG_5         active-low segment patterns, bit order g..a
//   SEG_BLANK              all segments off
//   state_t                checker FSM states
//   next_digit()           successor in the count-down sequence 5,4,3,2,1,0,5
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam int SEG_W   = 7;
    localparam int DIGIT_W = 4;
    localparam int CNT_W   = 10;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        LOCKED = 2'd1,
        ERR    = 2'd2
    } state_t;

    // The observed display counts down and wraps from 0 back to 5.
    function automatic logic [DIGIT_W-1:0] next_digit(input logic [DIGIT_W-1:0] d);
        return (d == '0) ? DIGIT_W'(5) : d - 1'b1;
    endfunction

endpackage

// File: rtl/seg_decode.sv
// -----------------------------------------------------------------------------
// seg_decode -- purely combinational segment-pattern to digit decoder.
//
// Ports:
//   pattern  in   active-low segment pattern, bit order g..a
//   digit    out  decoded digit 0..5 (0 when the pattern is invalid)
//   valid    out  1 when the pattern is one of the six recognised digits
// -----------------------------------------------------------------------------
module seg_decode
    import seg_pkg::*;
(
    input  logic [SEG_W-1:0]   pattern,
    output logic [DIGIT_W-1:0] digit,
    output logic               valid
);

    always_comb begin
        digit = '0;
        valid = 1'b1;
        case (pattern)
            SEG_0:   digit = DIGIT_W'(0);
            SEG_1:   digit = DIGIT_W'(1);
            SEG_2:   digit = DIGIT_W'(2);
            SEG_3:   digit = DIGIT_W'(3);
            SEG_4:   digit = DIGIT_W'(4);
            SEG_5:   digit = DIGIT_W'(5);
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_sequence_checker.sv
// -----------------------------------------------------------------------------
// seg_sequence_checker -- watches an asynchronous seven-segment pattern,
// accepts each new stable pattern and checks that the accepted digits follow
// the count-down sequence 5,4,3,2,1,0,5,...
//
// Parameters:
//   STABLE_CYCLES  consecutive identical synchronised samples needed before a
//                  pattern is accepted (1..1023); only used with the filter
//   ERR_MAX        saturation value of the error counter (at most 15)
//
// Ports:
//   CLOCK_50   in   50 MHz clock
//   KEY[0]     in   asynchronous active-low reset
//   SEG_IN     in   observed active-low segment pattern g..a, asynchronous
//   HEX0       out  last accepted valid pattern (blank after reset)
//   LEDR       out  [3:0] last valid digit, [4] last accept valid,
//                   [5] locked, [9:6] error count
//   LEDG[0]    out  one-cycle accept pulse
//
// Build option:
//   SEG_STABLE_FILTER_EN  defined   -> accept only after STABLE_CYCLES samples
//                         undefined -> accept every synchronised change
// -----------------------------------------------------------------------------
module seg_sequence_checker
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 1000,
    parameter int unsigned ERR_MAX       = 15
) (
    input  logic             CLOCK_50,
    input  logic [0:0]       KEY,
    input  logic [SEG_W-1:0] SEG_IN,
    output logic [SEG_W-1:0] HEX0,
    output logic [9:0]       LEDR,
    output logic [0:0]       LEDG
);

    // The error count is shown on four LEDs, so it cannot exceed 15.
    localparam logic [3:0] ERR_SAT = (ERR_MAX > 15) ? 4'd15 : 4'(ERR_MAX);

    if (STABLE_CYCLES < 1 || STABLE_CYCLES > 1023) begin : g_bad_stable_cycles
        $error("seg_sequence_checker: STABLE_CYCLES must be in 1..1023");
    end

    logic rst_n;
    assign rst_n = KEY[0];

    // -------------------------------------------------------------------------
    // Two-stage synchroniser. Both stages reset to the blank pattern so that
    // leaving reset never looks like a change away from a bogus all-zero value.
    // -------------------------------------------------------------------------
    logic [SEG_W-1:0] sync1_q, sync2_q;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= SEG_BLANK;
            sync2_q <= SEG_BLANK;
        end else begin
            sync1_q <= SEG_IN;
            sync2_q <= sync1_q;
        end
    end

    logic [SEG_W-1:0] last_q, last_d;
    logic             accept;

`ifdef SEG_STABLE_FILTER_EN
    // -------------------------------------------------------------------------
    // Stability filter. stable_cnt_q is the number of consecutive samples for
    // which sync2_q has held its present value. The count is computed from the
    // value sync2_q is about to take (sync1_q), so it reaches STABLE_LIM one
    // cycle before the registered accept pulse: 2 + STABLE_CYCLES edges after
    // SEG_IN settles.
    // -------------------------------------------------------------------------
    localparam logic [CNT_W-1:0] STABLE_LIM = CNT_W'(STABLE_CYCLES);

    logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;

    always_comb begin
        stable_cnt_d = stable_cnt_q;
        if (sync1_q != sync2_q) begin
            stable_cnt_d = CNT_W'(1);
        end else if (stable_cnt_q != STABLE_LIM) begin
            stable_cnt_d = stable_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            stable_cnt_q <= '0;
        end else begin
            stable_cnt_q <= stable_cnt_d;
        end
    end

    assign accept = (stable_cnt_q == STABLE_LIM) && (sync2_q != last_q);
`else
    // No filter: every synchronised change is accepted once.
    assign accept = (sync2_q != last_q);
`endif

    // -------------------------------------------------------------------------
    // Decode of the pattern being accepted.
    // -------------------------------------------------------------------------
    logic [DIGIT_W-1:0] dec_digit;
    logic               dec_valid;

    seg_decode u_decode (
        .pattern (sync2_q),
        .digit   (dec_digit),
        .valid   (dec_valid)
    );

    // -------------------------------------------------------------------------
    // Sequence FSM and output registers.
    // -------------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [DIGIT_W-1:0] expected_q, expected_d;
    logic [3:0]         err_q, err_d;
    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic               valid_q, valid_d;
    logic [SEG_W-1:0]   hex_q, hex_d;
    logic               locked_q, locked_d;
    logic               accept_q, accept_d;

    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        err_d      = err_q;
        last_d     = last_q;
        digit_d    = digit_q;
        valid_d    = valid_q;
        hex_d      = hex_q;
        accept_d   = accept;

        if (accept) begin
            last_d  = sync2_q;
            valid_d = dec_valid;
            if (dec_valid) begin
                digit_d = dec_digit;
                hex_d   = sync2_q;
            end

            case (state_q)
                LOCKED: begin
                    if (dec_valid && (dec_digit == expected_q)) begin
                        expected_d = next_digit(dec_digit);
                    end else begin
                        state_d = ERR;
                        if (err_q != ERR_SAT) begin
                            err_d = err_q + 1'b1;
                        end
                    end
                end
                // HUNT and ERR both re-sync on any valid digit; they differ
                // only in whether an invalid pattern counts as an error.
                default: begin
                    if (dec_valid) begin
                        state_d    = LOCKED;
                        expected_d = next_digit(dec_digit);
                    end else if (state_q == ERR) begin
                        if (err_q != ERR_SAT) begin
                            err_d = err_q + 1'b1;
                        end
                    end
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            expected_q <= '0;
            err_q      <= '0;
            last_q     <= SEG_BLANK;
            digit_q    <= '0;
            valid_q    <= 1'b0;
            hex_q      <= SEG_BLANK;
            locked_q   <= 1'b0;
            accept_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            err_q      <= err_d;
            last_q     <= last_d;
            digit_q    <= digit_d;
            valid_q    <= valid_d;
            hex_q      <= hex_d;
            locked_q   <= locked_d;
            accept_q   <= accept_d;
        end
    end

    assign HEX0 = hex_q;
    assign LEDR = {err_q, locked_q, valid_q, digit_q};
    assign LEDG = accept_q;

endmodule

// File: tb/tb_seg_sequence_checker.sv
// -----------------------------------------------------------------------------
// tb_seg_sequence_checker -- directed self-checking bench for
// seg_sequence_checker. Each driven pattern change that should be accepted
// pushes its expected pulse edge, LEDR and HEX0 onto a scoreboard; a monitor
// pops and compares when LEDG[0] pulses.
// -----------------------------------------------------------------------------
module tb_seg_sequence_checker;

    localparam int N = 1000;
`ifdef SEG_STABLE_FILTER_EN
    localparam int LAT    = 2 + N;
    localparam bit FILTER = 1'b1;
`else
    localparam int LAT    = 3;
    localparam bit FILTER = 1'b0;
`endif
    localparam int INV_HOLD = LAT + 3;

    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P1 = 7'b1111001;
    localparam logic [6:0] P2 = 7'b0100100;
    localparam logic [6:0] P3 = 7'b0110000;
    localparam logic [6:0] P4 = 7'b0011001;
    localparam logic [6:0] P5 = 7'b0010010;
    localparam logic [6:0] PB = 7'b1111111;

    localparam int S_HUNT = 0, S_LOCKED = 1, S_ERR = 2;

    logic       CLOCK_50 = 1'b0;
    logic [0:0] KEY;
    logic [6:0] SEG_IN;
    logic [6:0] HEX0;
    logic [9:0] LEDR;
    logic [0:0] LEDG;

    seg_sequence_checker #(
        .STABLE_CYCLES (N),
        .ERR_MAX       (15)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .KEY      (KEY),
        .SEG_IN   (SEG_IN),
        .HEX0     (HEX0),
        .LEDR     (LEDR),
        .LEDG     (LEDG)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int edge_cnt = 0;
    always @(posedge CLOCK_50) edge_cnt++;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int         due;
        logic [9:0] ledr;
        logic [6:0] hex;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Reference model state
    int         m_state = S_HUNT;
    int         m_exp   = 0;
    int         m_err   = 0;
    int         m_digit = 0;
    bit         m_valid = 1'b0;
    logic [6:0] m_hex   = PB;
    logic [6:0] m_last  = PB;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int dec(input logic [6:0] p);
        case (p)
            P0: return 0;
            P1: return 1;
            P2: return 2;
            P3: return 3;
            P4: return 4;
            P5: return 5;
            default: return -1;
        endcase
    endfunction

    function automatic logic [9:0] exp_ledr();
        return {4'(m_err), (m_state == S_LOCKED), m_valid, 4'(m_digit)};
    endfunction

    task automatic model_reset();
        m_state = S_HUNT;
        m_exp   = 0;
        m_err   = 0;
        m_digit = 0;
        m_valid = 1'b0;
        m_hex   = PB;
        m_last  = PB;
        sb.delete();
    endtask

    task automatic model_accept(input logic [6:0] p);
        int d;
        d = dec(p);
        m_valid = (d >= 0);
        if (d >= 0) begin
            m_digit = d;
            m_hex   = p;
        end
        if (m_state == S_LOCKED) begin
            if (d == m_exp) begin
                m_exp = (d == 0) ? 5 : d - 1;
            end else begin
                m_state = S_ERR;
                if (m_err < 15) m_err++;
            end
        end else if (d >= 0) begin
            m_state = S_LOCKED;
            m_exp   = (d == 0) ? 5 : d - 1;
        end else if (m_state == S_ERR) begin
            if (m_err < 15) m_err++;
        end
        m_last = p;
    endtask

    // Drive a pattern at a falling edge and hold it for n cycles.
    task automatic drive_hold(input logic [6:0] p, input int n);
        SEG_IN = p;
        if (p != m_last && (!FILTER || n >= N)) begin
            model_accept(p);
            sb.push_back('{edge_cnt + LAT, exp_ledr(), m_hex});
        end
        repeat (n) @(negedge CLOCK_50);
    endtask

    // Pulse monitor
    always @(negedge CLOCK_50) begin
        if (KEY[0] && LEDG[0]) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'(LEDG[0]), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                $display("pulse at edge %0d: LEDR=%b HEX0=%b", edge_cnt, LEDR, HEX0);
                check("pulse_edge", edge_cnt, mon_e.due);
                check("pulse_ledr", 32'(LEDR), 32'(mon_e.ledr));
                check("pulse_hex0", 32'(HEX0), 32'(mon_e.hex));
            end
        end else if (KEY[0] && sb.size() > 0 && edge_cnt > sb[0].due) begin
            check("missed_pulse", 32'(LEDG[0]), 32'd1);
            sb.delete(0);
        end
    end

    logic [6:0] seq_pats [7];
    logic [6:0] inv_pats [2];

    initial begin
        seq_pats = '{P5, P4, P3, P2, P1, P0, P5};
        inv_pats = '{7'b0000000, 7'b1111110};

        // Reset state
        KEY    = 1'b0;
        SEG_IN = PB;
        repeat (3) @(negedge CLOCK_50);
        check("reset_hex0", 32'(HEX0), 32'h7f);
        check("reset_ledr", 32'(LEDR), 32'd0);
        check("reset_ledg", 32'(LEDG), 32'd0);
        KEY = 1'b1;
        repeat (5) @(negedge CLOCK_50);

        // Full count-down sequence
        for (int i = 0; i < 7; i++) drive_hold(seq_pats[i], 2000);
        check("seq_locked", 32'(LEDR[5]), 32'd1);
        check("seq_errcnt", 32'(LEDR[9:6]), 32'd0);
        check("seq_hex0", 32'(HEX0), 32'(P5));

        // Short glitch while 4 is held
        drive_hold(P4, 2000);
`ifdef SEG_STABLE_FILTER_EN
        drive_hold(PB, 3);
        drive_hold(P4, 2000);
        check("glitch_locked", 32'(LEDR[5]), 32'd1);
        check("glitch_errcnt", 32'(LEDR[9:6]), 32'd0);
`else
        drive_hold(PB, 3);
        check("glitch_in_err", 32'(LEDR[5]), 32'd0);
        check("glitch_errcnt", 32'(LEDR[9:6]), 32'd1);
        drive_hold(P4, 2000);
`endif

        // Reset 500 cycles into the stability count of a new digit
        drive_hold(P5, 500);
        KEY = 1'b0;
        #1;
        check("midrst_hex0", 32'(HEX0), 32'h7f);
        check("midrst_ledr", 32'(LEDR), 32'd0);
        check("midrst_ledg", 32'(LEDG), 32'd0);
        model_reset();
        repeat (3) @(negedge CLOCK_50);
        check("midrst_hold_ledr", 32'(LEDR), 32'd0);
        KEY = 1'b1;
        drive_hold(P5, 2000);
        check("midrst_relock", 32'(LEDR[5]), 32'd1);

        // Sequence break 5,4,2 then re-sync on 1
        drive_hold(P4, 2000);
        drive_hold(P2, 2000);
        check("break_unlocked", 32'(LEDR[5]), 32'd0);
        check("break_errcnt", 32'(LEDR[9:6]), 32'd1);
        drive_hold(P1, 2000);
        check("resync_locked", 32'(LEDR[5]), 32'd1);
        drive_hold(P0, 2000);
        check("resync_exp0_locked", 32'(LEDR[5]), 32'd1);
        check("resync_exp0_errcnt", 32'(LEDR[9:6]), 32'd1);
        check("resync_exp0_digit", 32'(LEDR[3:0]), 32'd0);

        // Error counter saturation
        drive_hold(P3, 2000);
        for (int i = 0; i < 20; i++) drive_hold(inv_pats[i % 2], INV_HOLD);
        check("sat_errcnt", 32'(LEDR[9:6]), 32'd15);
        check("sat_unlocked", 32'(LEDR[5]), 32'd0);
        check("sat_valid", 32'(LEDR[4]), 32'd0);

        repeat (LAT + 10) @(negedge CLOCK_50);
        check("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
